// File: rtl/spi_mem_arbiter.sv
`default_nettype none
// =============================================================================
// spi_mem_arbiter : shares one QSPI transaction engine between fetch and data
// Rev 1.0 - initial release
// =============================================================================
module spi_mem_arbiter #(
    parameter logic [31:0] FLASH_BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] PSRAM_BASE_ADDR = 32'h0100_0000,
    parameter logic [31:0] REGION_SIZE     = 32'h0100_0000,
    parameter int unsigned DATA_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        e_start,
    output logic        e_sel,
    output logic [23:0] e_addr,
    output logic        e_we,
    output logic [1:0]  e_size,
    output logic [31:0] e_wdata,
    input  logic        e_done,
    input  logic [31:0] e_rdata,
    output logic        e_abort,
    output logic        busy,
    output logic        owner
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam int c_STREAK_W = $clog2(DATA_STREAK_MAX + 1);
    localparam int c_TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(DATA_STREAK_MAX);
    // Registered counter lags one cycle, so the last WAIT cycle sees TIMEOUT_CYCLES-2
    localparam logic [c_TMO_W-1:0]    c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYCLES - 2);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_owner;
    logic                  r_sel;
    logic [23:0]           r_off;
    logic                  r_we;
    logic [1:0]            r_size;
    logic [31:0]           r_wdata;
    logic                  r_illegal;
    logic                  r_err;
    logic [31:0]           r_i_rdata;
    logic [31:0]           r_d_rdata;
    logic [c_STREAK_W-1:0] r_streak;
    logic [c_TMO_W-1:0]    r_tmo;

    logic        w_grant;
    logic        w_pick_fetch;
    logic [31:0] w_req_addr;
    logic        w_req_we;
    logic [1:0]  w_req_size;
    logic [31:0] w_req_wdata;
    logic [31:0] w_off_flash;
    logic [31:0] w_off_psram;
    logic        w_in_flash;
    logic        w_in_psram;
    logic        w_illegal;
    logic        w_tmo_hit;
    logic        w_cap_en;
    logic [31:0] w_cap_data;

    // Winner selection and decode happen on the live request in IDLE
    always_comb begin
        w_grant      = i_req || d_req;
        w_pick_fetch = i_req && (!d_req || (r_streak == c_STREAK_MAX));
        if (w_pick_fetch) begin
            w_req_addr  = i_addr;
            w_req_we    = 1'b0;
            w_req_size  = 2'd2;
            w_req_wdata = 32'h0;
        end else begin
            w_req_addr  = d_addr;
            w_req_we    = d_we;
            w_req_size  = d_size;
            w_req_wdata = d_wdata;
        end
        w_off_flash = w_req_addr - FLASH_BASE_ADDR;
        w_off_psram = w_req_addr - PSRAM_BASE_ADDR;
        w_in_flash  = w_off_flash < REGION_SIZE;
        w_in_psram  = w_off_psram < REGION_SIZE;
        w_illegal   = !(w_in_flash || w_in_psram)
                   || (w_req_we && !w_in_psram)
                   || (w_req_size == 2'd3)
                   || ((w_req_size == 2'd1) && w_req_addr[0])
                   || ((w_req_size == 2'd2) && (w_req_addr[1:0] != 2'b00));
    end

    assign w_tmo_hit = (r_tmo == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_grant) w_state_nxt = c_ISSUE;
            c_ISSUE: w_state_nxt = r_illegal ? c_RESP : c_WAIT;
            c_WAIT:  if (e_done || w_tmo_hit) w_state_nxt = c_RESP;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Response data captured on the way into RESP; e_done beats timeout
    always_comb begin
        w_cap_en   = 1'b0;
        w_cap_data = 32'h0;
        if ((r_state == c_ISSUE) && r_illegal) begin
            w_cap_en = 1'b1;
        end else if (r_state == c_WAIT) begin
            if (e_done) begin
                w_cap_en   = 1'b1;
                w_cap_data = r_we ? 32'h0 : e_rdata;
            end else if (w_tmo_hit) begin
                w_cap_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner   <= 1'b0;
            r_sel     <= 1'b0;
            r_off     <= 24'h0;
            r_we      <= 1'b0;
            r_size    <= 2'd0;
            r_wdata   <= 32'h0;
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
            r_i_rdata <= 32'h0;
            r_d_rdata <= 32'h0;
            r_streak  <= '0;
            r_tmo     <= '0;
        end else begin
            if ((r_state == c_IDLE) && w_grant) begin
                r_owner   <= !w_pick_fetch;
                r_sel     <= w_in_psram;
                r_off     <= w_in_psram ? w_off_psram[23:0] : w_off_flash[23:0];
                r_we      <= w_req_we;
                r_size    <= w_req_size;
                r_wdata   <= w_req_wdata;
                r_illegal <= w_illegal;
                if (!w_pick_fetch && i_req) begin
                    r_streak <= r_streak + c_STREAK_W'(1);
                end else begin
                    r_streak <= '0;
                end
            end
            if (r_state == c_ISSUE) begin
                r_tmo <= '0;
                if (r_illegal) r_err <= 1'b1;
            end
            if (r_state == c_WAIT) begin
                r_tmo <= r_tmo + c_TMO_W'(1);
                if (e_done) begin
                    r_err <= 1'b0;
                end else if (w_tmo_hit) begin
                    r_err <= 1'b1;
                end
            end
            if (w_cap_en) begin
                if (r_owner) r_d_rdata <= w_cap_data;
                else         r_i_rdata <= w_cap_data;
            end
        end
    end

    always_comb begin
        e_start = (r_state == c_ISSUE) && !r_illegal;
        e_abort = (r_state == c_WAIT) && !e_done && w_tmo_hit;
        i_ack   = (r_state == c_RESP) && !r_owner;
        d_ack   = (r_state == c_RESP) && r_owner;
        i_err   = i_ack && r_err;
        d_err   = d_ack && r_err;
        busy    = (r_state != c_IDLE);
    end

    assign owner   = r_owner;
    assign e_sel   = r_sel;
    assign e_addr  = r_off;
    assign e_we    = r_we;
    assign e_size  = r_size;
    assign e_wdata = r_wdata;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_spi_mem_arbiter : directed self-checking bench for spi_mem_arbiter
// Rev 1.0 - initial release
// =============================================================================
module tb_spi_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        e_start;
    logic        e_sel;
    logic [23:0] e_addr;
    logic        e_we;
    logic [1:0]  e_size;
    logic [31:0] e_wdata;
    logic        e_done;
    logic [31:0] e_rdata;
    logic        e_abort;
    logic        busy;
    logic        owner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_mem_arbiter #(
        .FLASH_BASE_ADDR(32'h0000_0000),
        .PSRAM_BASE_ADDR(32'h0100_0000),
        .REGION_SIZE    (32'h0100_0000),
        .DATA_STREAK_MAX(4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .e_start(e_start), .e_sel(e_sel), .e_addr(e_addr), .e_we(e_we), .e_size(e_size),
        .e_wdata(e_wdata), .e_done(e_done), .e_rdata(e_rdata), .e_abort(e_abort),
        .busy(busy), .owner(owner)
    );

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_size = 2'd0; e_done = 1'b0; e_rdata = 32'h0;
        nxt(); nxt();
        rst_n = 1'b1;
        smp();
        total++;
        if ({busy, e_start, e_abort, i_ack, d_ack, i_err, d_err, owner, e_sel, e_we} !== 10'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0", {busy, e_start, e_abort, i_ack, d_ack, i_err, d_err, owner, e_sel, e_we});
        end
        total++;
        if ({e_addr, e_size, e_wdata} !== 58'h0) begin
            bad++; $display("FAIL reset_eng: addr=%h size=%0d wdata=%h want 0", e_addr, e_size, e_wdata);
        end
        total++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            bad++; $display("FAIL reset_rdata: i=%h d=%h want 0", i_rdata, d_rdata);
        end
    endtask

    task automatic test_fetch();
        nxt(); i_req = 1'b1; i_addr = 32'h0000_0100;
        smp();
        total++;
        if (busy !== 1'b0 || e_start !== 1'b0) begin
            bad++; $display("FAIL fetch_n: busy=%b e_start=%b want 0 0", busy, e_start);
        end
        nxt(); smp();
        total++;
        if ({e_start, busy, owner, e_sel, e_addr, e_we, e_size} !== {1'b1, 1'b1, 1'b0, 1'b0, 24'h000100, 1'b0, 2'd2}) begin
            bad++; $display("FAIL fetch_issue: start=%b busy=%b owner=%b sel=%b addr=%h we=%b size=%0d want 1 1 0 0 000100 0 2",
                            e_start, busy, owner, e_sel, e_addr, e_we, e_size);
        end
        nxt(); smp();
        total++;
        if (e_start !== 1'b0) begin
            bad++; $display("FAIL fetch_start_once: e_start=%b want 0", e_start);
        end
        nxt();
        nxt(); e_done = 1'b1; e_rdata = 32'hDEAD_BEEF;
        smp();
        total++;
        if (i_ack !== 1'b0) begin
            bad++; $display("FAIL fetch_early_ack: i_ack=%b want 0", i_ack);
        end
        nxt(); e_done = 1'b0; e_rdata = 32'h0;
        smp();
        total++;
        if ({i_ack, i_err, d_ack, i_rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL fetch_ack: ack=%b err=%b d_ack=%b rdata=%h want 1 0 0 deadbeef", i_ack, i_err, d_ack, i_rdata);
        end
        nxt(); i_req = 1'b0;
        smp();
        total++;
        if ({busy, i_ack, i_rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL fetch_hold: busy=%b ack=%b rdata=%h want 0 0 deadbeef", busy, i_ack, i_rdata);
        end
    endtask

    task automatic test_arbitration();
        logic exp_own [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic found;
        nxt();
        i_req = 1'b1; i_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0004; d_size = 2'd2; d_wdata = 32'h0;
        for (int g = 0; g < 10; g++) begin
            found = 1'b0;
            for (int w = 0; w < 6 && !found; w++) begin
                smp();
                if (e_start === 1'b1) found = 1'b1;
                else nxt();
            end
            total++;
            if (!found || owner !== exp_own[g]) begin
                bad++; $display("FAIL arb_grant%0d: started=%b owner=%b want 1 %b", g, found, owner, exp_own[g]);
            end
            nxt(); e_done = 1'b1; e_rdata = 32'h1000 + g;
            nxt(); e_done = 1'b0;
            smp();
            total++;
            if ({i_ack, d_ack, (exp_own[g] ? d_rdata : i_rdata)} !== {~exp_own[g], exp_own[g], 32'h1000 + g}) begin
                bad++; $display("FAIL arb_ack%0d: i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h want owner %b data %h",
                                g, i_ack, d_ack, i_rdata, d_rdata, exp_own[g], 32'h1000 + g);
            end
            nxt();
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_illegal();
        logic        t_we   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_addr [4] = '{32'h0000_0010, 32'h0200_0000, 32'h0100_0002, 32'h0100_0000};
        logic [1:0]  t_size [4] = '{2'd2, 2'd2, 2'd2, 2'd3};
        for (int k = 0; k < 4; k++) begin
            nxt(); d_req = 1'b1; d_we = t_we[k]; d_addr = t_addr[k]; d_size = t_size[k]; d_wdata = 32'hFFFF;
            nxt(); smp();
            total++;
            if ({e_start, busy} !== 2'b01) begin
                bad++; $display("FAIL illegal%0d_nostart: e_start=%b busy=%b want 0 1", k, e_start, busy);
            end
            nxt(); smp();
            total++;
            if ({d_ack, d_err, i_ack, d_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
                bad++; $display("FAIL illegal%0d_resp: ack=%b err=%b i_ack=%b rdata=%h want 1 1 0 0", k, d_ack, d_err, i_ack, d_rdata);
            end
            nxt(); d_req = 1'b0;
        end
    endtask

    task automatic test_write();
        nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0012; d_size = 2'd1; d_wdata = 32'h0000_A5A5;
        nxt(); smp();
        total++;
        if ({e_start, owner, e_sel, e_addr, e_we, e_size, e_wdata} !== {1'b1, 1'b1, 1'b1, 24'h000012, 1'b1, 2'd1, 32'h0000_A5A5}) begin
            bad++; $display("FAIL write_issue: start=%b owner=%b sel=%b addr=%h we=%b size=%0d wdata=%h want 1 1 1 000012 1 1 0000a5a5",
                            e_start, owner, e_sel, e_addr, e_we, e_size, e_wdata);
        end
        nxt(); e_done = 1'b1; e_rdata = 32'hFFFF_FFFF;
        nxt(); e_done = 1'b0; e_rdata = 32'h0;
        smp();
        total++;
        if ({d_ack, d_err, i_ack, d_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            bad++; $display("FAIL write_ack: ack=%b err=%b i_ack=%b rdata=%h want 1 0 0 0", d_ack, d_err, i_ack, d_rdata);
        end
        nxt(); d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic test_timeout();
        logic early;
        for (int v = 0; v < 2; v++) begin
            nxt(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0008; d_size = 2'd2;
            nxt(); smp();
            total++;
            if (e_start !== 1'b1) begin
                bad++; $display("FAIL tmo%0d_start: e_start=%b want 1", v, e_start);
            end
            early = 1'b0;
            for (int c = 2; c < 8; c++) begin
                nxt(); smp();
                if (e_abort !== 1'b0 || d_ack !== 1'b0) early = 1'b1;
            end
            total++;
            if (early !== 1'b0) begin
                bad++; $display("FAIL tmo%0d_early: abort or ack seen before last WAIT cycle=%b want 0", v, early);
            end
            nxt();
            if (v == 0) begin
                e_done = 1'b1; e_rdata = 32'h1234_5678;
            end
            smp();
            total++;
            if ({e_abort, d_ack} !== {(v == 1), 1'b0}) begin
                bad++; $display("FAIL tmo%0d_abort: e_abort=%b d_ack=%b want %0d 0", v, e_abort, d_ack, (v == 1));
            end
            nxt(); e_done = 1'b0; e_rdata = 32'h0;
            smp();
            total++;
            if ({d_ack, d_err, e_abort, d_rdata} !== {1'b1, (v == 1), 1'b0, ((v == 1) ? 32'h0 : 32'h1234_5678)}) begin
                bad++; $display("FAIL tmo%0d_resp: ack=%b err=%b abort=%b rdata=%h", v, d_ack, d_err, e_abort, d_rdata);
            end
            nxt(); d_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        nxt(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0020; d_size = 2'd0; d_wdata = 32'h1111;
        nxt(); smp();
        total++;
        if ({e_start, e_sel, e_addr, owner} !== {1'b1, 1'b1, 24'h000020, 1'b1}) begin
            bad++; $display("FAIL rstmid_issue: start=%b sel=%b addr=%h owner=%b want 1 1 000020 1", e_start, e_sel, e_addr, owner);
        end
        nxt(); rst_n = 1'b0; d_req = 1'b0;
        nxt(); rst_n = 1'b1;
        smp();
        total++;
        if ({busy, e_start, e_abort, i_ack, d_ack, i_err, d_err, owner, e_sel, e_we} !== 10'b0) begin
            bad++; $display("FAIL rstmid_ctrl: got %b want 0", {busy, e_start, e_abort, i_ack, d_ack, i_err, d_err, owner, e_sel, e_we});
        end
        total++;
        if ({e_addr, e_size, e_wdata, i_rdata, d_rdata} !== 122'h0) begin
            bad++; $display("FAIL rstmid_data: addr=%h size=%0d wdata=%h i_rdata=%h d_rdata=%h want 0", e_addr, e_size, e_wdata, i_rdata, d_rdata);
        end
        nxt(); e_done = 1'b1; e_rdata = 32'hBAD0_BAD0;
        nxt(); e_done = 1'b0; e_rdata = 32'h0;
        smp();
        total++;
        if ({busy, i_ack, d_ack, i_rdata, d_rdata} !== 67'h0) begin
            bad++; $display("FAIL stray_done: busy=%b i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h want 0", busy, i_ack, d_ack, i_rdata, d_rdata);
        end
        nxt(); d_req = 1'b1; d_addr = 32'h0100_0031; d_size = 2'd0;
        nxt(); smp();
        total++;
        if ({e_start, e_addr, e_size} !== {1'b1, 24'h000031, 2'd0}) begin
            bad++; $display("FAIL after_rst_issue: start=%b addr=%h size=%0d want 1 000031 0", e_start, e_addr, e_size);
        end
        nxt(); e_done = 1'b1; e_rdata = 32'h0000_005A;
        nxt(); e_done = 1'b0; e_rdata = 32'h0;
        smp();
        total++;
        if ({d_ack, d_err, d_rdata} !== {1'b1, 1'b0, 32'h0000_005A}) begin
            bad++; $display("FAIL after_rst_ack: ack=%b err=%b rdata=%h want 1 0 0000005a", d_ack, d_err, d_rdata);
        end
        nxt(); d_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_arbitration();
        test_illegal();
        test_write();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
